ulpi_reg_read: RTL and testbench
================================

ULPI_REG_READ -- requirements
Module: ulpi_reg_read

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be clk and rst as listed below.
REQ-002 The port clk SHALL be an input, 1 bit wide: the ULPI 60 MHz clock; all logic is rising-edge triggered.
REQ-003 The port rst SHALL be an input, 1 bit wide: asynchronous, active-low reset (0 = reset).
REQ-004 The port RD SHALL be an input, 1 bit wide: read request, sampled on a rising edge.
REQ-005 The port ADDR SHALL be an input, 6 bits wide: the register address, captured together with an accepted RD.
REQ-006 The port DATA SHALL be an output, 8 bits wide: the last register value read, held until the next read completes.
REQ-007 The port busy SHALL be an output, 1 bit wide: high while a read transaction is in progress.
REQ-008 The port DIR SHALL be an input, 1 bit wide: PHY bus direction (1 = PHY drives the bus).
REQ-009 The port STP SHALL be an output, 1 bit wide: ULPI stop signal.
REQ-010 The port NXT SHALL be an input, 1 bit wide: PHY throttle / accept signal.
REQ-011 The port ULPI_DATA_r SHALL be an input, 8 bits wide: bus value driven by the PHY, valid when DIR=1.
REQ-012 The port ULPI_DATA_w SHALL be an output, 8 bits wide: bus value driven by the link; it is used externally only when DIR=0.

Function
REQ-013 The module SHALL implement a registered FSM with the states IDLE, CMD, TURN1, READ and TURN2; busy SHALL be registered and equal to (state != IDLE).
REQ-014 In IDLE, if RD=1 at a clock edge, the module SHALL latch ADDR into addr_q and enter CMD; RD=0 SHALL keep the FSM in IDLE.
REQ-015 RD SHALL be ignored while busy=1; ADDR changes after acceptance SHALL have no effect.
REQ-016 In CMD, ULPI_DATA_w SHALL equal {2'b11, addr_q} (register-read TXCMD); in all other states ULPI_DATA_w SHALL be 8'h00.
REQ-017 In CMD with DIR=0 and NXT=1 at an edge, the FSM SHALL go to TURN1; with NXT=0 it SHALL stay in CMD.
REQ-018 In CMD with DIR=1 at an edge (PHY RX CMD preemption), the FSM SHALL go to TURN2 and then retry: once DIR returns to 0 it SHALL re-enter CMD with the same addr_q, keeping busy=1.
REQ-019 In TURN1, DIR=1 at an edge SHALL move the FSM to READ (turnaround cycle, no data capture); DIR=0 SHALL keep it in TURN1.
REQ-020 In READ, at the next edge, DATA SHALL be loaded with ULPI_DATA_r and the FSM SHALL go to TURN2.
REQ-021 In TURN2, at an edge with DIR=0, the FSM SHALL go to IDLE (or to CMD on the retry path), so busy falls one cycle after DIR falls; with DIR=1 it SHALL stay in TURN2.
REQ-022 STP SHALL be held at 0 at all times, since register reads do not use STP.
REQ-023 Latency with an immediately responsive PHY SHALL be: RD sampled at edge E0, TXCMD driven from E0, NXT sampled at E_n, DIR sampled high at E_n+1, DATA valid after E_n+2.

Reset
REQ-024 While rst=0, the module SHALL asynchronously force state=IDLE, DATA=8'h00, busy=0, STP=0, ULPI_DATA_w=8'h00 and addr_q=6'h00.
REQ-025 Reset asserted mid-transaction SHALL abort the transaction without updating DATA; after rst returns to 1, the FSM SHALL await a new RD.

Verification
REQ-026 Basic read SHALL be verified: RD=1 with ADDR=6'h1B for one edge -> ULPI_DATA_w=8'hDB and busy=1; NXT pulse -> TURN1; DIR=1 for 2 cycles with ULPI_DATA_r=8'h3D -> DATA=8'h3D; DIR=0 -> busy=0 and ULPI_DATA_w=8'h00.
REQ-027 NXT stall SHALL be verified: NXT held 0 for 10 cycles after RD -> ULPI_DATA_w stays 8'hDB and busy stays 1; then a normal completion -> correct DATA.
REQ-028 Preemption SHALL be verified: DIR=1 during CMD before NXT -> TXCMD withdrawn (8'h00); after DIR=0 -> TXCMD reissued; the read completes with the correct DATA.
REQ-029 RD while busy SHALL be verified: a second RD with ADDR=6'h05 mid-transaction -> ignored, ULPI_DATA_w never shows 8'hC5, and DATA reflects the first read only.
REQ-030 Async reset mid-read SHALL be verified: rst=0 in the READ state -> immediately busy=0 and ULPI_DATA_w=8'h00, with DATA=8'h00.
REQ-031 STP SHALL be checked to be 0 throughout every scenario.

Source files
------------

// File: rtl/ulpi_reg_read_if.sv
// ULPI register-read bundle: the requester side (RD/ADDR in, DATA/busy out) and the
// ULPI PHY side (DIR/NXT/ULPI_DATA_r in, STP/ULPI_DATA_w out).
//   master : view used by ulpi_reg_read (drives DATA, busy, STP, ULPI_DATA_w)
//   slave  : view used by whatever sits around it (drives RD, ADDR, DIR, NXT, ULPI_DATA_r)
interface ulpi_reg_read_if;
  logic       RD;
  logic [5:0] ADDR;
  logic [7:0] DATA;
  logic       busy;
  logic       DIR;
  logic       STP;
  logic       NXT;
  logic [7:0] ULPI_DATA_r;
  logic [7:0] ULPI_DATA_w;

  modport master (
    input  RD, ADDR, DIR, NXT, ULPI_DATA_r,
    output DATA, busy, STP, ULPI_DATA_w
  );

  modport slave (
    output RD, ADDR, DIR, NXT, ULPI_DATA_r,
    input  DATA, busy, STP, ULPI_DATA_w
  );
endinterface

// File: rtl/ulpi_reg_read.sv
// ULPI register read engine. On an accepted RD it issues a register-read TXCMD
// ({2'b11, addr}), waits for NXT, goes through the bus turnaround, captures the
// PHY's data byte into DATA and waits for the PHY to release the bus.
// If the PHY grabs the bus (DIR=1) before accepting the TXCMD, the read is
// retried once the bus is handed back.
//   clk : ULPI 60 MHz clock, rising edge
//   rst : asynchronous reset, active low
//   bus : ulpi_reg_read_if.master (RD, ADDR, DATA, busy, DIR, STP, NXT,
//         ULPI_DATA_r, ULPI_DATA_w)
module ulpi_reg_read (
  input  logic                  clk,
  input  logic                  rst,
  ulpi_reg_read_if.master       bus
);

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StTurn1,
    StRead,
    StTurn2
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       busy_q, busy_d;
  logic [7:0] txd_q, txd_d;
  // Set when TURN2 was entered because the PHY preempted the TXCMD.
  logic       retry_q, retry_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    retry_d = retry_q;

    unique case (state_q)
      StIdle: begin
        if (bus.RD) begin
          addr_d  = bus.ADDR;
          state_d = StCmd;
        end
      end
      StCmd: begin
        if (bus.DIR) begin
          retry_d = 1'b1;
          state_d = StTurn2;
        end else if (bus.NXT) begin
          state_d = StTurn1;
        end
      end
      StTurn1: begin
        if (bus.DIR) begin
          state_d = StRead;
        end
      end
      StRead: begin
        data_d  = bus.ULPI_DATA_r;
        retry_d = 1'b0;
        state_d = StTurn2;
      end
      StTurn2: begin
        if (!bus.DIR) begin
          state_d = retry_q ? StCmd : StIdle;
          retry_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        retry_d = 1'b0;
      end
    endcase

    // Outputs are registered from the next state so they change cleanly on the edge.
    busy_d = (state_d != StIdle);
    txd_d  = (state_d == StCmd) ? {2'b11, addr_d} : 8'h00;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= 6'h00;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      txd_q   <= 8'h00;
      retry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      txd_q   <= txd_d;
      retry_q <= retry_d;
    end
  end

  assign bus.DATA        = data_q;
  assign bus.busy        = busy_q;
  assign bus.ULPI_DATA_w = txd_q;
  assign bus.STP         = 1'b0;

endmodule

// File: tb/tb_ulpi_reg_read.sv
module tb_ulpi_reg_read;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ulpi_reg_read_if u_if ();

  ulpi_reg_read u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic       rd;
    logic [5:0] addr;
    logic       dir;
    logic       nxt;
    logic [7:0] data_r;
    logic       exp_busy;
    logic [7:0] exp_w;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h, expected %02h", name, act, exp);
  endtask

  task automatic chk_all(input string name, input logic busy, input logic [7:0] w,
                         input logic [7:0] data);
    chk({name, ".busy"}, {7'd0, u_if.busy}, {7'd0, busy});
    chk({name, ".wdata"}, u_if.ULPI_DATA_w, w);
    chk({name, ".DATA"}, u_if.DATA, data);
    chk({name, ".STP"}, {7'd0, u_if.STP}, 8'h00);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic [5:0] addr, input logic dir,
                       input logic nxt, input logic [7:0] dr);
    u_if.RD = rd; u_if.ADDR = addr; u_if.DIR = dir; u_if.NXT = nxt; u_if.ULPI_DATA_r = dr;
  endtask

  initial begin
    // Basic read of 0x1B returning 0x3D
    vecs[0]  = '{1'b1, 6'h1B, 1'b0, 1'b0, 8'h00, 1'b1, 8'hDB, 8'h00};
    vecs[1]  = '{1'b0, 6'h00, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 6'h00, 1'b1, 1'b0, 8'h3D, 1'b1, 8'h00, 8'h00};
    vecs[3]  = '{1'b0, 6'h00, 1'b1, 1'b0, 8'h3D, 1'b1, 8'h00, 8'h3D};
    vecs[4]  = '{1'b0, 6'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h3D};
    // Read of 0x2A, TURN1 held one extra cycle, data changes during READ
    vecs[5]  = '{1'b1, 6'h2A, 1'b0, 1'b0, 8'h00, 1'b1, 8'hEA, 8'h3D};
    vecs[6]  = '{1'b0, 6'h00, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 8'h3D};
    vecs[7]  = '{1'b0, 6'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h3D};
    vecs[8]  = '{1'b0, 6'h00, 1'b1, 1'b0, 8'hA5, 1'b1, 8'h00, 8'h3D};
    vecs[9]  = '{1'b0, 6'h00, 1'b1, 1'b0, 8'h5A, 1'b1, 8'h00, 8'h5A};
    vecs[10] = '{1'b0, 6'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 8'h5A};
    vecs[11] = '{1'b0, 6'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h5A};

    drive(1'b0, 6'h00, 1'b0, 1'b0, 8'h00);
    #12;
    chk_all("reset", 1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    step();
    chk_all("idle", 1'b0, 8'h00, 8'h00);

    foreach (vecs[i]) begin
      drive(vecs[i].rd, vecs[i].addr, vecs[i].dir, vecs[i].nxt, vecs[i].data_r);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].exp_busy, vecs[i].exp_w, vecs[i].exp_data);
    end

    // NXT stall for 10 cycles
    drive(1'b1, 6'h1B, 1'b0, 1'b0, 8'h00);
    step();
    chk_all("stall.cmd", 1'b1, 8'hDB, 8'h5A);
    drive(1'b0, 6'h00, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step();
      chk_all($sformatf("stall.wait%0d", i), 1'b1, 8'hDB, 8'h5A);
    end
    drive(1'b0, 6'h00, 1'b0, 1'b1, 8'h00); step();
    drive(1'b0, 6'h00, 1'b1, 1'b0, 8'h77); step(); step();
    chk_all("stall.data", 1'b1, 8'h00, 8'h77);
    drive(1'b0, 6'h00, 1'b0, 1'b0, 8'h00); step();
    chk_all("stall.done", 1'b0, 8'h00, 8'h77);

    // Preemption by the PHY during CMD, then retry
    drive(1'b1, 6'h0F, 1'b0, 1'b0, 8'h00); step();
    chk_all("pre.cmd", 1'b1, 8'hCF, 8'h77);
    drive(1'b0, 6'h00, 1'b1, 1'b0, 8'h11); step();
    chk_all("pre.withdrawn", 1'b1, 8'h00, 8'h77);
    step();
    chk_all("pre.rxcmd", 1'b1, 8'h00, 8'h77);
    drive(1'b0, 6'h00, 1'b0, 1'b0, 8'h00); step();
    chk_all("pre.reissue", 1'b1, 8'hCF, 8'h77);
    drive(1'b0, 6'h00, 1'b0, 1'b1, 8'h00); step();
    chk_all("pre.turn1", 1'b1, 8'h00, 8'h77);
    drive(1'b0, 6'h00, 1'b1, 1'b0, 8'h99); step(); step();
    chk_all("pre.data", 1'b1, 8'h00, 8'h99);
    drive(1'b0, 6'h00, 1'b0, 1'b0, 8'h00); step();
    chk_all("pre.done", 1'b0, 8'h00, 8'h99);

    // RD while busy must be ignored
    drive(1'b1, 6'h1B, 1'b0, 1'b0, 8'h00); step();
    chk_all("rdbusy.cmd", 1'b1, 8'hDB, 8'h99);
    drive(1'b1, 6'h05, 1'b0, 1'b1, 8'h00); step();
    chk_all("rdbusy.turn1", 1'b1, 8'h00, 8'h99);
    drive(1'b1, 6'h05, 1'b1, 1'b0, 8'h42); step();
    chk("rdbusy.noC5a", u_if.ULPI_DATA_w, 8'h00);
    step();
    chk_all("rdbusy.data", 1'b1, 8'h00, 8'h42);
    drive(1'b1, 6'h05, 1'b0, 1'b0, 8'h00); step();
    chk_all("rdbusy.done", 1'b0, 8'h00, 8'h42);
    drive(1'b0, 6'h00, 1'b0, 1'b0, 8'h00); step();
    chk_all("rdbusy.idle", 1'b0, 8'h00, 8'h42);

    // Async reset in READ
    drive(1'b1, 6'h1B, 1'b0, 1'b0, 8'h00); step();
    drive(1'b0, 6'h00, 1'b0, 1'b1, 8'h00); step();
    drive(1'b0, 6'h00, 1'b1, 1'b0, 8'hEE); step();
    chk_all("rst.inread", 1'b1, 8'h00, 8'h42);
    #2 rst = 1'b0;
    #1;
    chk_all("rst.async", 1'b0, 8'h00, 8'h00);
    step();
    chk_all("rst.held", 1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    drive(1'b0, 6'h00, 1'b0, 1'b0, 8'h00); step();
    chk_all("rst.after", 1'b0, 8'h00, 8'h00);
    drive(1'b1, 6'h2A, 1'b0, 1'b0, 8'h00); step();
    chk_all("rst.newrd", 1'b1, 8'hEA, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
